// File: rtl/matmul_dot_pkg.sv
// Shared types and width helpers for the matmul_dot inner-product engine.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_LEN_W  = 16;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int sum_w(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

endpackage

// File: rtl/matmul_dot_lane_sum.sv
// Combinational per-beat sum of LANES element products, signed or unsigned.
module matmul_lane_sum
    import matmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    localparam int SUM_W = sum_w(DATA_W, LANES)
) (
    input  logic                      is_signed,
    input  logic [LANES*DATA_W-1:0]   a,
    input  logic [LANES*DATA_W-1:0]   b,
    output logic [SUM_W-1:0]          sum
);

    // One extra operand bit lets a single signed multiplier serve both modes.
    localparam int PW = prod_w(DATA_W) + 2;
    localparam int TW = SUM_W + 1;

    logic signed [DATA_W:0] a_x;
    logic signed [DATA_W:0] b_x;
    logic signed [PW-1:0]   prod;
    logic signed [TW-1:0]   tot;

    always_comb begin
        a_x  = '0;
        b_x  = '0;
        prod = '0;
        tot  = '0;
        for (int i = 0; i < LANES; i++) begin
            a_x  = {is_signed & a[i*DATA_W + DATA_W - 1], a[i*DATA_W +: DATA_W]};
            b_x  = {is_signed & b[i*DATA_W + DATA_W - 1], b[i*DATA_W +: DATA_W]};
            prod = a_x * b_x;
            tot  = tot + TW'(prod);
        end
    end

    assign sum = SUM_W'(tot);

endmodule

// File: rtl/matmul_dot.sv
// Streaming dot-product engine: FSM, beat counter, accumulator and handshake.
// Define MATMUL_DOT_SAT_EN for a saturating accumulator with a sticky sat flag.
module matmul_dot
    import matmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    is_signed,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] a,
    input  logic [LANES*DATA_W-1:0] b,
    output logic [ACC_W-1:0]        y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    sat
);

    localparam int SUM_W = sum_w(DATA_W, LANES);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   y_q, y_d;
    logic [SUM_W-1:0]   beat_sum;
    logic [ACC_W-1:0]   acc_step;
    logic               beat;

    matmul_lane_sum #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_lane_sum (
        .is_signed (sgn_q),
        .a         (a),
        .b         (b),
        .sum       (beat_sum)
    );

    assign beat = (state_q == ACCUM) && in_valid;

`ifdef MATMUL_DOT_SAT_EN
    // Wide enough to hold acc + beat exactly even when the beat sum is wider than acc.
    localparam int XW = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    logic ovf;
    logic sat_q, sat_d;

    // Returns {overflow, clamped sum}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc_v,
                                               input logic [SUM_W-1:0] s,
                                               input logic sgn);
        logic [XW-1:0]    acc_x;
        logic [XW-1:0]    s_x;
        logic [XW-1:0]    tot;
        logic [ACC_W-1:0] lim;
        logic             o;
        if (sgn) begin
            acc_x = XW'($signed(acc_v));
            s_x   = XW'($signed(s));
        end else begin
            acc_x = XW'(acc_v);
            s_x   = XW'(s);
        end
        tot = acc_x + s_x;
        if (sgn) begin
            o   = !((&tot[XW-1:ACC_W-1]) || !(|tot[XW-1:ACC_W-1]));
            lim = tot[XW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            o   = |tot[XW-1:ACC_W];
            lim = '1;
        end
        return {o, (o ? lim : tot[ACC_W-1:0])};
    endfunction

    always_comb begin
        {ovf, acc_step} = sat_add(acc_q, beat_sum, sgn_q);
    end

    always_comb begin
        sat_d = sat_q;
        if (state_q == IDLE && start) begin
            sat_d = 1'b0;
        end else if (beat && ovf) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] acc_v,
                                                  input logic [SUM_W-1:0] s,
                                                  input logic sgn);
        logic [ACC_W-1:0] s_x;
        if (sgn) begin
            s_x = ACC_W'($signed(s));
        end else begin
            s_x = ACC_W'(s);
        end
        return acc_v + s_x;
    endfunction

    always_comb begin
        acc_step = wrap_add(acc_q, beat_sum, sgn_q);
    end

    assign sat = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = len;
                    sgn_d = is_signed;
                    acc_d = '0;
                    cnt_d = '0;
                    if (len == '0) begin
                        y_d     = '0;
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        y_d     = acc_step;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;

endmodule
